sigmoid_pipe: RTL and testbench
===============================

SIGMOID_PIPE -- requirements
Module: sigmoid_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 22: input fixed-point width, with sign at bit IN_W-1.
REQ-002 SHALL have parameter ADDR_LSB, default 5: lowest input bit used as LUT address.
REQ-003 SHALL have parameter ADDR_W, default 9: LUT address width per sign half.
REQ-004 SHALL have parameter OUT_W, default 8: unsigned activation output width.
REQ-005 SHALL have parameter CNT_W, default 16: saturation counter width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1 bit: input word valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-010 SHALL have port din, input, IN_W bits: two's-complement pre-activation.
REQ-011 SHALL have port act_sel, input, 1 bit: 0 selects sigmoid, 1 selects saturating ReLU; sampled with din.
REQ-012 SHALL have port out_valid, output, 1 bit: dout valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts dout.
REQ-014 SHALL have port dout, output, OUT_W bits: activation result.
REQ-015 SHALL have port sat_cnt, output, CNT_W bits: count of saturated results.
REQ-016 SHALL have port sat_clr, input, 1 bit: synchronous clear of sat_cnt.

Function
REQ-017 SHALL compute adv = out_ready | ~out_valid and drive in_ready = adv; a transfer occurs on in_valid & in_ready.
REQ-018 SHALL use a 3-stage pipeline: S1 classify/register, S2 synchronous LUT read, S3 output mux/register. All stages advance only when adv=1; a stall freezes every stage, including the LUT read enable.
REQ-019 SHALL present the result 3 advancing cycles after acceptance, giving throughput of 1 word per cycle with no bubbles while out_ready=1.
REQ-020 SHALL preserve order and neither drop nor duplicate words under arbitrary out_ready patterns; dout SHALL be held stable while out_valid & ~out_ready.
REQ-021 SHALL define fields as: sign = din[IN_W-1]; hi = din[IN_W-2 : ADDR_LSB+ADDR_W]; addr = din[ADDR_LSB+ADDR_W-1 : ADDR_LSB].
REQ-022 SHALL produce a sigmoid positive overflow when sign=0 and |hi is 1; dout = all ones.
REQ-023 SHALL produce a sigmoid negative overflow when sign=1 and either &hi is 0 or addr is 0; dout = 0.
REQ-024 SHALL otherwise produce a sigmoid result dout = LUT[{sign, addr}], where the LUT has 2^(ADDR_W+1) entries of OUT_W bits.
REQ-025 SHALL, for ReLU with sign=1, produce dout = 0, not counted as saturation.
REQ-026 SHALL, for ReLU with sign=0, produce dout = all ones if any bit of din[IN_W-2 : ADDR_LSB+OUT_W] is set; otherwise dout = din[ADDR_LSB+OUT_W-1 : ADDR_LSB].
REQ-027 SHALL increment sat_cnt once per output transfer (out_valid & out_ready) whose result came from an overflow path (REQ-022, REQ-023, or REQ-026 all-ones case).
REQ-028 SHALL stick sat_cnt at all ones, never wrapping.
REQ-029 SHALL give sat_clr priority over a simultaneous increment; the counter becomes 0 that cycle.
REQ-030 SHALL require ADDR_LSB+ADDR_W <= IN_W-2 and ADDR_LSB+OUT_W <= IN_W-1, checked at elaboration.

Reset
REQ-031 SHALL, when rst=1, clear on the next edge the stage valids, out_valid and sat_cnt, and set dout=0; in_ready=1 after reset.
REQ-032 SHALL discard in-flight words on reset mid-stream, with no output emitted from them.
REQ-033 SHALL not reset LUT contents.

Structure
REQ-034 SHALL place default widths, the act_sel encodings (ACT_SIGMOID=0, ACT_RELU=1) and the Q-format constants in shared package nn_act_pkg.
REQ-035 SHALL instantiate one sub-module, sigmoid_rom: synchronous-read LUT with en, a (ADDR_W+1) address, OUT_W data and a memory-init file parameter.

Verification (defaults)
REQ-036 SHALL verify that din=22'h000000 with sigmoid selected yields dout=LUT[0] (0x80) exactly 3 cycles later and leaves sat_cnt unchanged.
REQ-037 SHALL verify that din=22'h004000 with sigmoid selected yields dout=0xFF and sat_cnt=1; din=22'h3FC000 with sigmoid selected yields dout=0x00 and sat_cnt=2.
REQ-038 SHALL verify that ReLU with din=22'h001FE0 yields 0xFF; din=22'h000FE0 yields 0x7F; din=22'h200000 yields 0x00.
REQ-039 SHALL verify that streaming 8 words with out_ready low for 5 cycles mid-burst delivers all 8 in order, with dout stable throughout the stall.
REQ-040 SHALL verify that asserting rst with 2 words in flight yields no out_valid afterwards, sat_cnt=0 and in_ready=1.
REQ-041 SHALL verify that with CNT_W=2, 5 overflow transfers give sat_cnt=3, and that sat_clr asserted in the same cycle as an overflow transfer gives 0.

Source files
------------

// File: rtl/nn_act_pkg.sv
// Shared widths, activation encodings and Q-format constants
// for the fixed-point activation pipeline.
package nn_act_pkg;

    localparam int IN_W_DEF     = 22;
    localparam int ADDR_LSB_DEF = 5;
    localparam int ADDR_W_DEF   = 9;
    localparam int OUT_W_DEF    = 8;
    localparam int CNT_W_DEF    = 16;

    localparam logic ACT_SIGMOID = 1'b0;
    localparam logic ACT_RELU    = 1'b1;

    // din LSB weight is 2^-Q_FRAC
    localparam int Q_FRAC = 11;

    // Piecewise-linear sigmoid for x >= 0, x in Q_FRAC units,
    // result scaled by 2^out_w (may reach 2^out_w, caller clips).
    function automatic longint sig_plan(input longint xq, input int out_w);
        longint s;
        longint one;
        s   = longint'(1) << out_w;
        one = longint'(1) << Q_FRAC;
        if (xq < one)
            return s / 2 + xq * s / (4 * one);
        else if (xq < 19 * one / 8)
            return 5 * s / 8 + xq * s / (8 * one);
        else if (xq < 5 * one)
            return 27 * s / 32 + xq * s / (32 * one);
        return s;
    endfunction

endpackage

// File: rtl/sigmoid_rom.sv
// Synchronous-read sigmoid table indexed by {sign, addr}.
// Contents are generated in-line from the package curve.
module sigmoid_rom
    import nn_act_pkg::*;
#(
    parameter int    ADDR_W    = ADDR_W_DEF,
    parameter int    OUT_W     = OUT_W_DEF,
    parameter int    ADDR_LSB  = ADDR_LSB_DEF,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              en,
    input  logic [ADDR_W:0]   a,
    output logic [OUT_W-1:0]  q
);

    if (INIT_FILE != "") begin : g_no_file
        $error("sigmoid_rom: only the generated table is available");
    end

    // Negative half uses sigma(-x) = 1 - sigma(x); addr counts up from -2^ADDR_W.
    function automatic logic [OUT_W-1:0] entry(input logic [ADDR_W:0] idx);
        longint s;
        longint m;
        longint y;
        s = longint'(1) << OUT_W;
        m = longint'(idx[ADDR_W-1:0]);
        if (idx[ADDR_W])
            m = (longint'(1) << ADDR_W) - m;
        y = sig_plan(m << ADDR_LSB, OUT_W);
        if (idx[ADDR_W])
            y = s - y;
        if (y > s - 1)
            y = s - 1;
        if (y < 0)
            y = 0;
        return y[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (en)
            q <= entry(a);
    end

endmodule

// File: rtl/sigmoid_pipe.sv
// Three-stage sigmoid / saturating-ReLU activation pipeline
// with valid/ready flow control and a sticky saturation counter.
module sigmoid_pipe
    import nn_act_pkg::*;
#(
    parameter int IN_W     = IN_W_DEF,
    parameter int ADDR_LSB = ADDR_LSB_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   din,
    input  logic              act_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  dout,
    output logic [CNT_W-1:0]  sat_cnt,
    input  logic              sat_clr
);

    localparam int HI_LO = ADDR_LSB + ADDR_W;
    localparam int RL_LO = ADDR_LSB + OUT_W;

    if (HI_LO > IN_W - 2) begin : g_bad_addr
        $error("sigmoid_pipe: ADDR_LSB+ADDR_W must be <= IN_W-2");
    end
    if (RL_LO > IN_W - 1) begin : g_bad_out
        $error("sigmoid_pipe: ADDR_LSB+OUT_W must be <= IN_W-1");
    end

    logic adv;
    logic take;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign take     = in_valid & adv;

    logic                    sgn;
    logic [IN_W-2-HI_LO:0]   hi;
    logic [ADDR_W-1:0]       addr;
    logic                    relu;
    logic                    relu_big;
    logic                    unused_lsb;
    assign sgn        = din[IN_W-1];
    assign hi         = din[IN_W-2:HI_LO];
    assign addr       = din[HI_LO-1:ADDR_LSB];
    assign relu       = act_sel == ACT_RELU;
    assign relu_big   = |din[IN_W-2:RL_LO];
    assign unused_lsb = ^din[ADDR_LSB-1:0];

    logic             c_lut;
    logic             c_sat;
    logic [OUT_W-1:0] c_val;

    always_comb begin
        c_lut = 1'b0;
        c_sat = 1'b0;
        c_val = '0;
        unique case (1'b1)
            relu & sgn: ;
            relu & ~sgn & relu_big: begin
                c_sat = 1'b1;
                c_val = '1;
            end
            relu & ~sgn & ~relu_big:
                c_val = din[RL_LO-1:ADDR_LSB];
            ~relu & ~sgn & (|hi): begin
                c_sat = 1'b1;
                c_val = '1;
            end
            ~relu & sgn & (~(&hi) | (addr == '0)):
                c_sat = 1'b1;
            default:
                c_lut = 1'b1;
        endcase
    end

    logic             v1, lut1, sat1;
    logic [OUT_W-1:0] val1;
    logic [ADDR_W:0]  a1;
    logic             v2, lut2, sat2;
    logic [OUT_W-1:0] val2;
    logic             sat3;
    logic [OUT_W-1:0] rom_q;

    sigmoid_rom #(
        .ADDR_W   (ADDR_W),
        .OUT_W    (OUT_W),
        .ADDR_LSB (ADDR_LSB)
    ) u_rom (
        .clk (clk),
        .en  (adv),
        .a   (a1),
        .q   (rom_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (adv) begin
            v1        <= take;
            lut1      <= c_lut;
            sat1      <= c_sat;
            val1      <= c_val;
            a1        <= {sgn, addr};
            v2        <= v1;
            lut2      <= lut1;
            sat2      <= sat1;
            val2      <= val1;
            out_valid <= v2;
            if (v2) begin
                dout <= lut2 ? rom_q : val2;
                sat3 <= sat2;
            end
        end
    end

    // Counter sticks at all ones; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst)
            sat_cnt <= '0;
        else if (sat_clr)
            sat_cnt <= '0;
        else if (out_valid & out_ready & sat3 & ~(&sat_cnt))
            sat_cnt <= sat_cnt + 1'b1;
    end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// Randomized and directed bench for sigmoid_pipe against a
// behavioural activation model and an output scoreboard.
module tb_sigmoid_pipe;

    typedef struct {
        int d;
        bit s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, act_sel;
    logic [21:0] din;
    logic        out_valid, out_ready, sat_clr;
    logic [7:0]  dout;
    logic [15:0] sat_cnt;

    logic        in2_valid, in2_ready, act2, out2_valid, out2_ready, sat2_clr;
    logic [21:0] din2;
    logic [7:0]  dout2;
    logic [1:0]  sat2_cnt;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   cnt_m = 0;
    bit   mon_on = 0;
    bit   held = 0;
    int   held_val;
    exp_t q[$];

    always #5 clk = ~clk;

    sigmoid_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .act_sel(act_sel), .out_valid(out_valid),
        .out_ready(out_ready), .dout(dout), .sat_cnt(sat_cnt),
        .sat_clr(sat_clr)
    );

    sigmoid_pipe #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in2_valid), .in_ready(in2_ready),
        .din(din2), .act_sel(act2), .out_valid(out2_valid),
        .out_ready(out2_ready), .dout(dout2), .sat_cnt(sat2_cnt),
        .sat_clr(sat2_clr)
    );

    task automatic check(string tag, longint obs, longint exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Sigmoid curve in real arithmetic; table index {neg, a}, x = value/64.
    function automatic int lut_ref(bit neg, int a);
        int  m;
        real x, y;
        int  p;
        m = neg ? 512 - a : a;
        x = real'(m) * 32.0 / 2048.0;
        if (x < 1.0)        y = 0.25 * x + 0.5;
        else if (x < 2.375) y = 0.125 * x + 0.625;
        else if (x < 5.0)   y = 0.03125 * x + 0.84375;
        else                y = 1.0;
        p = int'($floor(y * 256.0));
        if (neg) p = 256 - p;
        if (p > 255) p = 255;
        if (p < 0) p = 0;
        return p;
    endfunction

    function automatic exp_t model(logic [21:0] d, logic a);
        exp_t e;
        e.s = 0;
        e.d = 0;
        if (a) begin
            if (d[21])                e.d = 0;
            else if (d[20:13] != 0) begin e.d = 255; e.s = 1; end
            else                      e.d = int'(d[12:5]);
        end else if (!d[21] && d[20:14] != 0) begin
            e.d = 255; e.s = 1;
        end else if (d[21] && (d[20:14] != 7'h7F || d[13:5] == 0)) begin
            e.d = 0; e.s = 1;
        end else begin
            e.d = lut_ref(d[21], int'(d[13:5]));
        end
        return e;
    endfunction

    function automatic logic [21:0] gen();
        case ($urandom % 4)
            0: return 22'($urandom);
            1: return {1'b0, 7'd0, 14'($urandom)};
            2: return {1'b1, 7'h7F, 14'($urandom)};
            default: return 22'($urandom_range(0, 16383));
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit   fire;
        if (mon_on) begin
            check("sat_cnt", sat_cnt, cnt_m);
            if (rst) begin
                q.delete();
                cnt_m = 0;
                held = 0;
            end else begin
                if (held && out_valid) check("hold", dout, held_val);
                held = 0;
                fire = 0;
                if (out_valid) begin
                    if (q.size() == 0)
                        check("spurious_valid", out_valid, 0);
                    else if (out_ready) begin
                        e = q.pop_front();
                        check("dout", dout, e.d);
                        fire = e.s;
                        n_out++;
                    end else begin
                        held = 1;
                        held_val = int'(dout);
                    end
                end
                if (sat_clr) cnt_m = 0;
                else if (fire && cnt_m != 65535) cnt_m++;
                if (in_valid && in_ready) q.push_back(model(din, act_sel));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(logic [21:0] d, logic a);
        bit acc;
        int g;
        g = 0;
        in_valid = 1; din = d; act_sel = a;
        do begin
            @(negedge clk);
            acc = in_ready;
            cyc();
            g++;
        end while (!acc && g < 50);
        in_valid = 0;
        if (!acc) check("send_timeout", acc, 1);
    endtask

    task automatic run_one(string tag, logic [21:0] d, logic a,
                           int exp_d, int exp_sat);
        int lat;
        send_word(d, a);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, 3);
        check(tag, dout, exp_d);
        cyc();
        @(negedge clk);
        check({tag, "_sat"}, sat_cnt, exp_sat);
        cyc();
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 60) begin
            cyc();
            g++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        int  sent, c, n0;
        bit  seen;
        rst = 1; in_valid = 0; din = '0; act_sel = 0;
        out_ready = 1; sat_clr = 0;
        in2_valid = 0; din2 = 22'h004000; act2 = 0;
        out2_ready = 1; sat2_clr = 0;
        cyc();
        mon_on = 1;
        cyc();
        rst = 0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sat", sat_cnt, 0);
        check("rst_dout", dout, 0);
        cyc();

        run_one("sig_zero", 22'h000000, 0, 8'h80, 0);
        run_one("sig_pos_ovf", 22'h004000, 0, 8'hFF, 1);
        run_one("sig_neg_ovf", 22'h3FC000, 0, 8'h00, 2);
        run_one("relu_top", 22'h001FE0, 1, 8'hFF, 2);
        run_one("relu_mid", 22'h000FE0, 1, 8'h7F, 2);
        run_one("relu_neg", 22'h200000, 1, 8'h00, 2);
        run_one("relu_ovf", 22'h002000, 1, 8'hFF, 3);

        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            din       = gen();
            act_sel   = $urandom % 2;
            out_ready = ($urandom % 4) != 0;
            sat_clr   = ($urandom % 50) == 0;
            @(negedge clk);
            cyc();
        end
        in_valid = 0; out_ready = 1; sat_clr = 0;
        drain();

        sent = 0; c = 0; n0 = n_out;
        while (sent < 8 && c < 100) begin
            in_valid  = 1;
            din       = gen();
            act_sel   = $urandom % 2;
            out_ready = !(c >= 3 && c < 8);
            @(negedge clk);
            if (in_ready) sent++;
            cyc();
            c++;
        end
        in_valid = 0; out_ready = 1;
        drain();
        check("burst_count", n_out - n0, 8);

        in_valid = 1; din = 22'h004000; act_sel = 0;
        cyc();
        cyc();
        in_valid = 0;
        rst = 1;
        cyc();
        rst = 0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check("rst_no_out", seen, 0);
        check("rst_in_ready2", in_ready, 1);
        check("rst_sat2", sat_cnt, 0);
        cyc();

        for (int i = 0; i < 5; i++) begin
            in2_valid = 1;
            cyc();
        end
        in2_valid = 0;
        repeat (6) cyc();
        @(negedge clk);
        check("sat_sticky", sat2_cnt, 3);
        check("dut2_in_ready", in2_ready, 1);
        cyc();
        in2_valid = 1;
        cyc();
        in2_valid = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out2_valid) break;
        end
        check("ovf2_seen", out2_valid, 1);
        check("ovf2_dout", dout2, 8'hFF);
        sat2_clr = 1;
        cyc();
        sat2_clr = 0;
        @(negedge clk);
        check("clr_prio", sat2_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
